// File: rtl/pa_lsu_sram_par_ctrl.sv
// LSU SRAM access controller: owns the 1024x36 single-port macro pins,
// packs 32-bit data with one odd-parity bit per byte, initialises the whole
// array after reset, then serves one read or byte-masked write per cycle.
// Read data is parity-checked; the first failing address is captured sticky.

// Per-byte parity lane: generate side for writes, check side for reads.
module pa_lsu_par_byte (
  input  logic [7:0] wbyte,
  output logic       wpar,
  input  logic [7:0] rbyte,
  input  logic       rpar,
  output logic       rerr
);
  // Odd parity: data plus parity bit must hold an odd number of ones.
  assign wpar = ~^wbyte;
  assign rerr = ~^{rpar, rbyte};
endmodule

module pa_lsu_sram_par_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int SRAM_WIDTH = DATA_WIDTH + DATA_WIDTH/8
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                  rsp_vld,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [DATA_WIDTH/8-1:0] rsp_err,
  output logic                  init_done,
  output logic                  err_vld,
  output logic [ADDR_WIDTH-1:0] err_addr,
  input  logic                  err_clr,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [SRAM_WIDTH-1:0] sram_wen,
  output logic [SRAM_WIDTH-1:0] sram_d,
  input  logic [SRAM_WIDTH-1:0] sram_q
);
  localparam int NB = DATA_WIDTH/8;

  typedef enum logic [1:0] {INIT_PEND, INIT, RUN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  rsp_vld_q;
  logic [ADDR_WIDTH-1:0] rsp_addr_q;
  logic                  err_vld_q;
  logic [ADDR_WIDTH-1:0] err_addr_q;

  logic [NB-1:0]         wpar, rerr;
  logic [SRAM_WIDTH-1:0] wr_wen;
  logic                  rd_acc, wr_acc, err_hit;

  // One parity lane per byte; write-enable mask follows the byte enables,
  // covering both the data byte and its parity bit.
  for (genvar b = 0; b < NB; b++) begin : g_byte
    pa_lsu_par_byte u_par (
      .wbyte (req_wdata[8*b +: 8]),
      .wpar  (wpar[b]),
      .rbyte (sram_q[8*b +: 8]),
      .rpar  (sram_q[DATA_WIDTH+b]),
      .rerr  (rerr[b])
    );
    assign wr_wen[8*b +: 8]      = {8{~req_be[b]}};
    assign wr_wen[DATA_WIDTH+b]  = ~req_be[b];
  end

  assign req_rdy   = (state_q == RUN);
  assign rd_acc    = req_rdy & req_vld & ~req_wr;
  // A write with no bytes enabled is accepted but leaves the macro idle.
  assign wr_acc    = req_rdy & req_vld & req_wr & (|req_be);
  assign rsp_vld   = rsp_vld_q;
  assign rsp_rdata = sram_q[DATA_WIDTH-1:0];
  assign rsp_err   = rerr;
  assign init_done = init_done_q;
  assign err_vld   = err_vld_q;
  assign err_addr  = err_addr_q;
  assign err_hit   = rsp_vld_q & (|rerr);

  // Next-state: one idle cycle after reset, then sweep every address.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      INIT_PEND: state_d = INIT;
      INIT: begin
        init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        if (init_cnt_q == {ADDR_WIDTH{1'b1}}) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT_PEND;
    endcase
  end

  // SRAM pins: idle by default, init sweep writes zero data with valid parity.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (state_q == INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_cnt_q;
      sram_d    = {{NB{1'b1}}, {DATA_WIDTH{1'b0}}};
    end else if (rd_acc) begin
      sram_cen  = 1'b0;
      sram_a    = req_addr;
    end else if (wr_acc) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = wr_wen;
      sram_a    = req_addr;
      sram_d    = {wpar, req_wdata};
    end
  end

  // FSM and init counter registers.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= INIT_PEND;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Read response tracking: valid plus address of the read in flight.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rsp_vld_q  <= 1'b0;
      rsp_addr_q <= '0;
    end else begin
      rsp_vld_q  <= rd_acc;
      if (rd_acc) rsp_addr_q <= req_addr;
    end
  end

  // Sticky first-error capture; a new error beats a concurrent clear.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      err_vld_q  <= 1'b0;
      err_addr_q <= '0;
    end else if (err_hit) begin
      err_vld_q <= 1'b1;
      if (!err_vld_q || err_clr) err_addr_q <= rsp_addr_q;
    end else if (err_clr) begin
      err_vld_q  <= 1'b0;
      err_addr_q <= '0;
    end
  end
endmodule

// File: tb/tb_pa_lsu_sram_par_ctrl.sv
// Bench for pa_lsu_sram_par_ctrl: SRAM macro model with read-bit corruption,
// word-level reference memory, scoreboard queue drained by a negedge monitor.
module tb_pa_lsu_sram_par_ctrl;
  logic        clk = 1'b0;
  logic        cpurst_b = 1'b0;
  logic        req_vld = 1'b0, req_wr = 1'b0, err_clr = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        req_rdy, rsp_vld, init_done, err_vld;
  logic [31:0] rsp_rdata;
  logic [3:0]  rsp_err;
  logic [9:0]  err_addr, sram_a;
  logic        sram_cen, sram_gwen;
  logic [35:0] sram_wen, sram_d, sram_q;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  err;
  } exp_t;
  exp_t sb[$];

  logic [35:0] mem [1024];
  bit          flip [1024];
  logic [31:0] ref_mem [1024];
  logic        m_vld = 1'b0;
  logic [9:0]  m_addr = '0;

  pa_lsu_sram_par_ctrl dut (
    .forever_cpuclk(clk), .cpurst_b(cpurst_b),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .init_done(init_done), .err_vld(err_vld), .err_addr(err_addr),
    .err_clr(err_clr), .sram_a(sram_a), .sram_cen(sram_cen),
    .sram_gwen(sram_gwen), .sram_wen(sram_wen), .sram_d(sram_d),
    .sram_q(sram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Macro model: bit-masked write, registered read with optional bit-0 flip.
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a] ^ (flip[sram_a] ? 36'h1 : 36'h0);
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare responses and error-capture state against the model.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!cpurst_b) begin
        sb.delete();
        m_vld = 1'b0;
        m_addr = '0;
      end else begin
        chk("err_vld", err_vld, m_vld);
        chk("err_addr", err_addr, m_addr);
        if (sb.size() > 0 && sb[0].due < cyc) begin
          chk("rsp_late", cyc, sb[0].due);
          void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
          e = sb.pop_front();
          chk("rsp_vld", rsp_vld, 1'b1);
          if (rsp_vld) begin
            chk("rsp_rdata", rsp_rdata, e.data);
            chk("rsp_err", rsp_err, e.err);
          end
          if (|e.err) begin
            if (!m_vld || err_clr) m_addr = e.addr;
            m_vld = 1'b1;
          end else if (err_clr) begin
            m_vld = 1'b0;
            m_addr = '0;
          end
        end else begin
          chk("rsp_spurious", rsp_vld, 1'b0);
          if (err_clr) begin
            m_vld = 1'b0;
            m_addr = '0;
          end
        end
      end
    end
  end

  // Issue one request this cycle; record expectation; check SRAM pins.
  task automatic drive(input logic wr, input logic [9:0] addr, input logic [31:0] data,
                       input logic [3:0] be);
    exp_t e;
    logic [35:0] ewen;
    logic [3:0]  par;
    req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = data; req_be = be;
    if (!wr) begin
      e.due  = cyc + 1;
      e.addr = addr;
      e.data = ref_mem[addr] ^ (flip[addr] ? 32'h1 : 32'h0);
      e.err  = flip[addr] ? 4'b0001 : 4'b0000;
      sb.push_back(e);
    end else begin
      for (int i = 0; i < 4; i++)
        if (be[i]) ref_mem[addr][8*i +: 8] = data[8*i +: 8];
    end
    #1;
    if (!wr) chk("rd_pins", {sram_cen, sram_gwen, sram_a}, {1'b0, 1'b1, addr});
    else if (be == 4'h0) chk("nop_wr_cen", sram_cen, 1'b1);
    else begin
      ewen = '1;
      for (int i = 0; i < 4; i++)
        if (be[i]) begin
          ewen[8*i +: 8] = 8'h0;
          ewen[32+i] = 1'b0;
        end
      chk("wr_pins", {sram_cen, sram_gwen, sram_a, sram_wen, sram_d[31:0]},
          {1'b0, 1'b0, addr, ewen, data});
      for (int i = 0; i < 4; i++)
        par[i] = ($countones({sram_d[32+i], sram_d[8*i +: 8]}) % 2) == 1;
      chk("wr_par_odd", par, 4'hF);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    req_vld = 1'b0;
  endtask

  // Follow the init sweep from INIT_PEND; optionally reset at address stop_at.
  task automatic init_seq(input int stop_at);
    chk("init_pend_cen", {sram_cen, req_rdy, init_done}, {1'b1, 1'b0, 1'b0});
    for (int k = 0; k < 1024; k++) begin
      @(posedge clk); #1;
      chk("init_pins", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d, req_rdy, init_done},
          {1'b0, 1'b0, 36'h0, 10'(k), 36'hF_0000_0000, 1'b0, 1'b0});
      if (k == stop_at) begin
        cpurst_b = 1'b0;
        #1;
        chk("midinit_rst", {sram_cen, init_done, req_rdy}, {1'b1, 1'b0, 1'b0});
        return;
      end
    end
    @(posedge clk); #1;
    chk("init_done", {init_done, req_rdy, sram_cen}, {1'b1, 1'b1, 1'b1});
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) flip[i] = 1'b0;
    flip[10'h200] = 1'b1; flip[10'h201] = 1'b1; flip[10'h202] = 1'b1;

    // Reset values, then an init aborted at address 500.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vals", {req_rdy, rsp_vld, init_done, err_vld, err_addr, sram_cen, sram_gwen, sram_wen},
        {1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b1, 1'b1, 36'hF_FFFF_FFFF});
    cpurst_b = 1'b1;
    init_seq(500);
    @(posedge clk); #1;
    chk("rst_hold_idle", {sram_cen, sram_a, init_done}, {1'b1, 10'h0, 1'b0});
    cpurst_b = 1'b1;
    init_seq(-1);

    // Full write then read.
    drive(1'b1, 10'h155, 32'hA5A50F01, 4'hF);
    chk("t2_wr_d", {sram_d, sram_wen}, {36'hE_A5A50F01, 36'h0});
    step();
    drive(1'b0, 10'h155, 32'h0, 4'h0); step();
    step();

    // Partial write of byte 1, read back.
    drive(1'b1, 10'h155, 32'h0000_7700, 4'b0010);
    chk("t3_wen", sram_wen, 36'hD_FFFF_00FF);
    chk("t3_d33", sram_d[33], 1'b1);
    step();
    drive(1'b0, 10'h155, 32'h0, 4'h0); step();
    step();

    // Parity errors: first capture sticks, clear racing a new error.
    drive(1'b0, 10'h200, 32'h0, 4'h0); step();
    step();
    chk("t4_first", {err_vld, err_addr}, {1'b1, 10'h200});
    drive(1'b0, 10'h201, 32'h0, 4'h0); step();
    step();
    chk("t4_sticky", {err_vld, err_addr}, {1'b1, 10'h200});
    drive(1'b0, 10'h202, 32'h0, 4'h0); step();
    err_clr = 1'b1; step();
    err_clr = 1'b0;
    chk("t4_clr_race", {err_vld, err_addr}, {1'b1, 10'h202});

    // No-op write, then read/write/read back-to-back.
    drive(1'b1, 10'h155, 32'hFFFF_FFFF, 4'h0); step();
    drive(1'b0, 10'h155, 32'h0, 4'h0); step();
    drive(1'b1, 10'h155, 32'h1234_5678, 4'hF); step();
    drive(1'b0, 10'h155, 32'h0, 4'h0); step();
    step();

    // Reset in the cycle after a read accept: response is dropped.
    drive(1'b0, 10'h155, 32'h0, 4'h0); step();
    cpurst_b = 1'b0;
    #1;
    chk("rdrst", {rsp_vld, init_done, sram_cen, req_rdy}, {1'b0, 1'b0, 1'b1, 1'b0});
    @(posedge clk); #1;
    cpurst_b = 1'b1;
    init_seq(-1);

    // Randomized traffic over a small window including the corrupt words.
    for (int n = 0; n < 400; n++) begin
      err_clr = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0: ;
        1, 2: drive(1'b0, 10'($urandom_range(10'h1F8, 10'h207)), 32'h0, 4'h0);
        default: drive(1'b1, 10'($urandom_range(10'h1F8, 10'h207)), $urandom(),
                       4'($urandom_range(0, 15)));
      endcase
      step();
    end
    err_clr = 1'b0;
    repeat (3) step();
    chk("sb_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pa_lsu_sram_par_ctrl.md
Name: pa_lsu_sram_par_ctrl

Overview:
- Access controller sitting directly upstream of the LSU 1024x36 single-port SRAM wrapper; owns all of its pins (A, CEN, GWEN, WEN, D) and consumes Q.
- Packs 32-bit data with 4 odd-parity bits (one per byte) into the 36-bit word.
- Initialises the whole array after reset, then serves one read or byte-masked write per cycle.
- Checks parity on read data and reports per-byte errors, with sticky first-error capture.

Parameters:
- ADDR_WIDTH, 10, SRAM address width; depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 32, payload width; byte count = DATA_WIDTH/8.
- SRAM_WIDTH, 36, SRAM word width = DATA_WIDTH + DATA_WIDTH/8.

Ports:
- forever_cpuclk  in  1  clock.
- cpurst_b  in  1  reset, asynchronous, active-low.
- req_vld  in  1  request valid.
- req_rdy  out  1  request ready.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  10  word address.
- req_wdata  in  32  write data.
- req_be  in  4  byte enables (writes only).
- rsp_vld  out  1  read data valid.
- rsp_rdata  out  32  read data.
- rsp_err  out  4  per-byte parity error, qualified by rsp_vld.
- init_done  out  1  array initialised.
- err_vld  out  1  sticky parity-error flag.
- err_addr  out  10  address of first captured error.
- err_clr  in  1  clears err_vld and err_addr.
- sram_a  out  10  SRAM A.
- sram_cen  out  1  SRAM CEN, active low.
- sram_gwen  out  1  SRAM GWEN, 0 = write.
- sram_wen  out  36  SRAM per-bit write enable, active low.
- sram_d  out  36  SRAM D.
- sram_q  in  36  SRAM Q, valid the cycle after a read.

Behaviour:
- Clock and reset: single clock forever_cpuclk; cpurst_b is asynchronous, active-low.
- Word layout: bits [31:0] = data. Bit 32+i = parity of byte i = ~^data[8i+7:8i], so data plus parity has an odd number of ones.
- FSM states: INIT_PEND (reset state), INIT, RUN.
- INIT_PEND:
  - SRAM idle: cen=1, gwen=1, wen=all 1, a=0, d=0.
  - Moves to INIT on the first clock edge after reset release.
- INIT:
  - Each cycle drives cen=0, gwen=0, wen=0, a=init_cnt, d=36'hF_0000_0000.
  - init_cnt (10-bit) increments each cycle.
  - When init_cnt==1023 at an edge: move to RUN and set init_done=1 at that edge. init_cnt wraps to 0.
  - req_rdy=0 throughout INIT.
- RUN:
  - req_rdy=1 every cycle; no backpressure; responses cannot be stalled.
  - Accepted read (req_vld & ~req_wr): combinationally drive cen=0, gwen=1, a=req_addr. The rsp_vld flop sets at that edge.
  - Next cycle: rsp_vld=1, rsp_rdata=sram_q[31:0], rsp_err[i]=~^{sram_q[32+i], sram_q[8i+7:8i]}. Read latency is 1 cycle.
  - Accepted write with req_be!=0: drive cen=0, gwen=0, a=req_addr, d={parity(req_wdata), req_wdata}.
    - wen[8i+7:8i] and wen[32+i] = ~req_be[i]; all other wen bits = 1.
    - No response is generated for writes.
  - Write with req_be==0: accepted, but SRAM stays idle (cen=1).
  - No accepted request: SRAM idle with the same pin values as INIT_PEND.
  - Back-to-back accesses are allowed every cycle. A write in the cycle after a read does not disturb the read's rsp_rdata.
- Error capture:
  - When rsp_vld & |rsp_err at an edge: err_vld<=1. err_addr<=the address of that read, only if err_vld was 0.
  - The read address is held in a flop alongside rsp_vld.
  - err_clr clears both err_vld and err_addr. If a new error occurs in the same cycle as err_clr, the new error wins: err_vld=1, err_addr=new address.
- rsp_rdata and rsp_err are don't-care when rsp_vld=0. The bench checks them only when rsp_vld=1.
- Reset values: req_rdy=0, rsp_vld=0, init_done=0, err_vld=0, err_addr=0, init_cnt=0, state=INIT_PEND.
  - With cpurst_b low, SRAM pins take the idle values immediately.
- Reset mid-operation:
  - Asynchronously abort any in-flight read: rsp_vld drops and no response is produced.
  - Re-run the full initialisation from address 0.

Test Plan:
1. Release reset:
   - First cycle: cen=1.
   - Next 1024 cycles: cen=0, gwen=0, wen=0, a=0..1023 ascending, d=36'hF_00000000.
   - init_done and req_rdy rise at the edge that writes address 1023.
2. Full write then read:
   - Write addr 0x155, data 0xA5A50F01, be=4'hF -> sram_d=36'hE_A5A50F01, wen=0.
   - Read 0x155 -> next cycle rsp_vld=1, rsp_rdata=0xA5A50F01, rsp_err=0.
3. Partial write:
   - be=4'b0010, data 0x00007700 to 0x155 -> wen low only on bits [15:8] and bit 33; sram_d[33]=1.
   - Read back -> 0xA5A57701, rsp_err=0.
4. Parity error:
   - Bench model flips sram_q[0] on a read of 0x200 -> rsp_rdata=0x00000001, rsp_err=4'b0001; err_vld=1 and err_addr=0x200 next edge.
   - Second error at 0x201 -> err_addr stays 0x200.
   - err_clr concurrent with an error at 0x202 -> err_addr=0x202.
5. Sequencing and no-op write:
   - Write with be=0 -> cen stays 1, no rsp_vld.
   - Read / write / read to the same address on consecutive cycles -> first read returns the old data, second read returns the new data, each exactly 1 cycle after its request.
6. Reset mid-init and mid-read:
   - Assert cpurst_b low at init_cnt=500 -> cen=1 and init_done=0 immediately; after release, init restarts at address 0.
   - Reset in the cycle after a read accept -> rsp_vld=0, no response.
